rf_scoreboard: RTL and testbench
================================

Name: rf_scoreboard

Overview:
- Parametrised successor to the fixed 8x16 register file of the processor datapath.
- Provides configurable width and depth, two combinational read ports and one write port.
- Adds optional write-to-read bypass, an optional hardwired zero register, a per-register busy scoreboard for pipeline hazard detection, and a sticky error flag.
- Sits between decode (reads, reserve) and writeback (write).

Parameters:
- WIDTH, 16, data bits per register.
- NREG, 8, number of registers (2..32; need not be a power of two).
- SELW, 3, selector width; must satisfy 2**SELW >= NREG.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports.
- ZERO_REG, 0, when 1 register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- read1regsel  in  SELW  read port 1 register select.
- read2regsel  in  SELW  read port 2 register select.
- writeregsel  in  SELW  write register select.
- writedata  in  WIDTH  write data.
- write  in  1  write enable.
- reserve  in  1  mark reserveregsel busy (instruction issued with pending result).
- reserveregsel  in  SELW  register to reserve.
- read1data  out  WIDTH  read port 1 data (combinational).
- read2data  out  WIDTH  read port 2 data (combinational).
- read1busy  out  1  read port 1 register has an outstanding result.
- read2busy  out  1  read port 2 register has an outstanding result.
- err  out  1  sticky error flag (registered).

Behaviour:
- Reset: clk and rst are the only clock and reset; rst is synchronous, active-high, sampled on the rising edge of clk. On a rising edge with rst=1, all registers are cleared to 0, all busy bits to 0 and err to 0. rst overrides write and reserve in the same cycle.
- Reset output values: read data 0, busy outputs 0, err 0 from the first cycle after the reset edge.
- Write:
  - If write=1 and writeregsel<NREG, reg[writeregsel] takes writedata at the edge.
  - Ignored when ZERO_REG=1 and writeregsel=0.
- Read (per port):
  - readNdata = reg[sel], with no clock latency.
  - If ZERO_REG=1 and sel=0, output 0.
  - If sel>=NREG, output 0.
  - Bypass hit: BYPASS=1, write=1, writeregsel==sel, and the target is not the zero register. On a hit, readNdata = writedata in the same cycle.
  - With BYPASS=0, new data is visible one cycle after the write edge.
- Scoreboard:
  - busy[i] is set at the edge when reserve=1 and reserveregsel=i.
  - busy[i] is cleared at the edge when write=1 and writeregsel=i.
  - If reserve and write target the same register in one cycle, reserve wins and busy stays or becomes 1 (a new producer supersedes).
  - Reserve of register 0 with ZERO_REG=1 is ignored.
- Busy outputs:
  - readNbusy = busy[sel] & ~(bypass hit on that port).
  - readNbusy = 0 for sel>=NREG or for the zero register.
- err: set at the edge, and held until rst, on any of:
  - (a) an enabled port (write, reserve) with selector >= NREG;
  - (b) reserve of a register that is already busy and not being written in the same cycle (WAW on an outstanding result).
  - An illegal read select does not set err.
- Simultaneous reads of the same register on both ports: both outputs are identical, and bypass applies to each independently.
- Reset mid-operation: outstanding reservations are discarded, and a write in the reset cycle is lost.

Test Plan:
- Reset: load reg3=16'h1234, reserve r5, assert rst 1 cycle -> all reads 16'h0000, read busy 0, err 0.
- Write/read with BYPASS=1: write r2=16'hBEEF, read1regsel=2 in the same cycle -> read1data=16'hBEEF that cycle. With BYPASS=0 -> old value (0) that cycle, 16'hBEEF next cycle.
- Scoreboard: reserve r4 -> next cycle read2busy=1 with read2regsel=4. Then write r4=16'h00AA -> read2busy=0 in the write cycle (bypass), busy bit cleared after the edge.
- Reserve and write to r6 in the same cycle (busy r6 previously set) -> r6=new data, busy stays 1, err stays 0.
- err: reserve r1 twice without an intervening write -> err=1 from the cycle after the second reserve, stays 1 until rst. With NREG=6, write to sel=7 -> err=1, no register changes.
- ZERO_REG=1: write r0=16'hFFFF, reserve r0 -> read r0 gives 16'h0000, busy 0, err 0.

Source files
------------

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: parametrised register file, two comb read ports, one write
// port, write-to-read bypass, optional zero reg, busy scoreboard, sticky err.
// Ports: clk, rst (sync, active-high); read{1,2}regsel -> read{1,2}data and
//   read{1,2}busy; write/writeregsel/writedata; reserve/reserveregsel; err.
module rf_scoreboard #(
  parameter int WIDTH    = 16,
  parameter int NREG     = 8,
  parameter int SELW     = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SELW-1:0]  read1regsel,
  input  logic [SELW-1:0]  read2regsel,
  input  logic [SELW-1:0]  writeregsel,
  input  logic [WIDTH-1:0] writedata,
  input  logic             write,
  input  logic             reserve,
  input  logic [SELW-1:0]  reserveregsel,
  output logic [WIDTH-1:0] read1data,
  output logic [WIDTH-1:0] read2data,
  output logic             read1busy,
  output logic             read2busy,
  output logic             err
);

  logic [WIDTH-1:0] r_regs [NREG];
  logic [NREG-1:0]  r_busy;
  logic             r_err;

  logic w_wr_bad, w_rs_bad;
  logic w_wr_zero, w_rs_zero;
  logic w_wr_ok, w_rs_ok;
  logic w_rs_busy, w_waw;

  logic [SELW-1:0]  w_rsel  [2];
  logic [WIDTH-1:0] w_rdata [2];
  logic             w_rbusy [2];
  logic             w_hit   [2];

  assign w_wr_bad  = write && (int'(writeregsel) >= NREG);
  assign w_rs_bad  = reserve && (int'(reserveregsel) >= NREG);
  assign w_wr_zero = (ZERO_REG != 0) && (writeregsel == '0);
  assign w_rs_zero = (ZERO_REG != 0) && (reserveregsel == '0);
  assign w_wr_ok   = write && !w_wr_bad && !w_wr_zero;
  assign w_rs_ok   = reserve && !w_rs_bad && !w_rs_zero;

  // Loop-based lookup keeps the busy read width-safe for any NREG/SELW.
  always_comb begin
    w_rs_busy = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (reserveregsel == SELW'(i)) w_rs_busy = r_busy[i];
    end
  end

  // A new producer on a busy register is only legal if the old
  // result is retiring in the same cycle.
  assign w_waw = w_rs_ok && w_rs_busy &&
                 !(write && (writeregsel == reserveregsel));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_wr_ok && (writeregsel == SELW'(i)))
          r_regs[i] <= writedata;
        // Reserve beats write-back: the newer producer owns the reg.
        if (w_rs_ok && (reserveregsel == SELW'(i)))
          r_busy[i] <= 1'b1;
        else if (w_wr_ok && (writeregsel == SELW'(i)))
          r_busy[i] <= 1'b0;
      end
      if (w_wr_bad || w_rs_bad || w_waw) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_rsel[0] = read1regsel;
    w_rsel[1] = read2regsel;
    for (int p = 0; p < 2; p++) begin
      w_rdata[p] = '0;
      w_rbusy[p] = 1'b0;
      w_hit[p]   = (BYPASS != 0) && w_wr_ok &&
                   (writeregsel == w_rsel[p]);
      for (int i = 0; i < NREG; i++) begin
        if ((w_rsel[p] == SELW'(i)) &&
            !((ZERO_REG != 0) && (i == 0))) begin
          w_rdata[p] = r_regs[i];
          w_rbusy[p] = r_busy[i];
        end
      end
      if (w_hit[p]) begin
        w_rdata[p] = writedata;
        w_rbusy[p] = 1'b0;
      end
    end
  end

  assign read1data = w_rdata[0];
  assign read2data = w_rdata[1];
  assign read1busy = w_rbusy[0];
  assign read2busy = w_rbusy[1];
  assign err       = r_err;

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: drives two configurations of rf_scoreboard with shared
// stimulus and checks them against a behavioural model.
module tb_rf_scoreboard;

  logic        clk = 1'b0;
  logic        rst, write, reserve;
  logic [2:0]  r1s, r2s, ws, rs;
  logic [15:0] wd;

  logic [15:0] rd1 [2];
  logic [15:0] rd2 [2];
  logic        b1  [2];
  logic        b2  [2];
  logic        er  [2];

  int checks = 0;
  int errors = 0;

  localparam int NR [2] = '{8, 6};
  localparam int BP [2] = '{1, 0};
  localparam int ZR [2] = '{0, 1};

  logic [15:0] mem  [2][8];
  bit          bsy  [2][8];
  bit          merr [2];

  always #5 clk = ~clk;

  rf_scoreboard #(.WIDTH(16), .NREG(8), .SELW(3),
                  .BYPASS(1), .ZERO_REG(0)) u0 (
    .clk(clk), .rst(rst),
    .read1regsel(r1s), .read2regsel(r2s),
    .writeregsel(ws), .writedata(wd), .write(write),
    .reserve(reserve), .reserveregsel(rs),
    .read1data(rd1[0]), .read2data(rd2[0]),
    .read1busy(b1[0]), .read2busy(b2[0]), .err(er[0]));

  rf_scoreboard #(.WIDTH(16), .NREG(6), .SELW(3),
                  .BYPASS(0), .ZERO_REG(1)) u1 (
    .clk(clk), .rst(rst),
    .read1regsel(r1s), .read2regsel(r2s),
    .writeregsel(ws), .writedata(wd), .write(write),
    .reserve(reserve), .reserveregsel(rs),
    .read1data(rd1[1]), .read2data(rd2[1]),
    .read1busy(b1[1]), .read2busy(b2[1]), .err(er[1]));

  function automatic bit m_hit(int k, int sel);
    return BP[k] != 0 && write && int'(ws) == sel &&
           sel < NR[k] && !(ZR[k] != 0 && sel == 0);
  endfunction

  function automatic logic [15:0] m_rd(int k, int sel);
    if (sel >= NR[k]) return 16'h0;
    if (ZR[k] != 0 && sel == 0) return 16'h0;
    if (m_hit(k, sel)) return wd;
    return mem[k][sel];
  endfunction

  function automatic bit m_busy(int k, int sel);
    if (sel >= NR[k]) return 1'b0;
    if (ZR[k] != 0 && sel == 0) return 1'b0;
    if (m_hit(k, sel)) return 1'b0;
    return bsy[k][sel];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rd1_u%0d", k), 32'(rd1[k]), 32'(m_rd(k, int'(r1s))));
      chk($sformatf("rd2_u%0d", k), 32'(rd2[k]), 32'(m_rd(k, int'(r2s))));
      chk($sformatf("b1_u%0d", k), 32'(b1[k]), 32'(m_busy(k, int'(r1s))));
      chk($sformatf("b2_u%0d", k), 32'(b2[k]), 32'(m_busy(k, int'(r2s))));
      chk($sformatf("err_u%0d", k), 32'(er[k]), 32'(merr[k]));
    end
  endtask

  task automatic drive(bit r, bit w, int wsel, logic [15:0] d,
                       bit rv, int rsel, int s1, int s2);
    rst = r; write = w; ws = 3'(wsel); wd = d;
    reserve = rv; rs = 3'(rsel); r1s = 3'(s1); r2s = 3'(s2);
  endtask

  // Model state update from the rules applied at the clock edge.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) begin
          mem[k][i] = 16'h0;
          bsy[k][i] = 1'b0;
        end
        merr[k] = 1'b0;
      end else begin
        int wi = int'(ws);
        int ri = int'(rs);
        bit wok = write && wi < NR[k] && !(ZR[k] != 0 && wi == 0);
        bit rok = reserve && ri < NR[k] && !(ZR[k] != 0 && ri == 0);
        if (write && wi >= NR[k]) merr[k] = 1'b1;
        if (reserve && ri >= NR[k]) merr[k] = 1'b1;
        if (rok && bsy[k][ri] && !(write && wi == ri)) merr[k] = 1'b1;
        if (wok) begin
          mem[k][wi] = wd;
          bsy[k][wi] = 1'b0;
        end
        if (rok) bsy[k][ri] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic step(bit r, bit w, int wsel, logic [15:0] d,
                      bit rv, int rsel, int s1, int s2);
    drive(r, w, wsel, d, rv, rsel, s1, s2);
    #3;
    check_all();
    tick();
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();

    step(0, 1, 3, 16'h1234, 1, 5, 3, 5);
    step(0, 0, 0, 0, 0, 0, 3, 5);
    step(1, 1, 3, 16'h5555, 1, 5, 3, 5);
    drive(0, 0, 0, 0, 0, 0, 3, 5);
    #3;
    chk("rst_rd1", 32'(rd1[0]), 32'h0);
    chk("rst_b2", 32'(b2[0]), 32'h0);
    chk("rst_err", 32'(er[0]), 32'h0);
    check_all();
    tick();

    drive(0, 1, 2, 16'hBEEF, 0, 0, 2, 2);
    #3;
    chk("byp_u0", 32'(rd1[0]), 32'hBEEF);
    chk("nobyp_u1", 32'(rd1[1]), 32'h0);
    check_all();
    tick();
    drive(0, 0, 0, 0, 0, 0, 2, 2);
    #3;
    chk("late_u1", 32'(rd1[1]), 32'hBEEF);
    check_all();
    tick();

    step(0, 0, 0, 0, 1, 4, 0, 4);
    drive(0, 1, 4, 16'h00AA, 0, 0, 0, 4);
    #3;
    chk("busy_byp_u0", 32'(b2[0]), 32'h0);
    chk("busy_nobyp_u1", 32'(b2[1]), 32'h1);
    check_all();
    tick();
    step(0, 0, 0, 0, 0, 0, 0, 4);

    step(0, 0, 0, 0, 1, 6, 6, 6);
    step(0, 1, 6, 16'h6666, 1, 6, 6, 6);
    drive(0, 0, 0, 0, 0, 0, 6, 6);
    #3;
    chk("rw6_data", 32'(rd1[0]), 32'h6666);
    chk("rw6_busy", 32'(b1[0]), 32'h1);
    chk("rw6_err", 32'(er[0]), 32'h0);
    check_all();
    tick();

    step(0, 0, 0, 0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    chk("waw_err_u0", 32'(er[0]), 32'h1);
    step(0, 1, 1, 16'h0001, 0, 0, 1, 1);
    chk("err_sticky", 32'(er[0]), 32'h1);

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 7, 16'h7777, 0, 0, 7, 5);
    chk("oob_err_u1", 32'(er[1]), 32'h1);
    step(0, 0, 0, 0, 0, 0, 7, 5);

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 16'hFFFF, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("zr_data", 32'(rd1[1]), 32'h0);
    chk("zr_busy", 32'(b1[1]), 32'h0);
    chk("zr_err", 32'(er[1]), 32'h0);
    check_all();
    tick();

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 7)),
           16'($urandom),
           $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
